// File: rtl/pixel_readout_decoder.sv
// Pixel-chain readout: shifts each pixel's 10-bit LFSR word out of the daisy
// chain, decodes it to an event count by walking the LFSR, and serves it on valid/ready.
module pixel_readout_decoder #(
  parameter int N_PIX      = 16,
  parameter int BIT_CYCLES = 4,
  parameter int IDX_W      = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Ser_in,
  output logic             Shift,
  output logic             Sh_pulse,
  output logic [9:0]       Pix_data,
  output logic             Pix_err,
  output logic [IDX_W-1:0] Pix_addr,
  output logic             Pix_valid,
  input  logic             Pix_ready,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       Dbg_state
);

  // Handshake: a word transfers on a rising Clk edge with Pix_valid && Pix_ready;
  // while Pix_valid is high without Pix_ready, Pix_data/Pix_err/Pix_addr stay put.

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DECODE, S_OUTPUT} state_t;

  localparam int               PH_W       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_PIX - 1);

  state_t           r_state;
  state_t           w_next;
  logic [PH_W-1:0]  r_phase;
  logic [3:0]       r_bit_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [9:0]       r_w;
  logic [9:0]       r_l;
  logic [9:0]       r_c;
  logic [9:0]       r_data;
  logic             r_err;
  logic             r_done;

  logic       w_last_phase;
  logic       w_last_bit;
  logic       w_lockup;
  logic       w_match;
  logic       w_guard;
  logic       w_accept;
  logic       w_last_pix;
  logic [9:0] w_l_next;

  assign w_last_phase = (r_phase == LAST_PHASE);
  assign w_last_bit   = (r_bit_cnt == 4'd9);
  assign w_lockup     = (r_w == 10'h3FF);
  assign w_match      = (r_l == r_w);
  // No legal word survives 1022 steps without matching, so this only fires on corruption.
  assign w_guard      = (r_c == 10'd1022);
  assign w_accept     = Pix_valid && Pix_ready;
  assign w_last_pix   = (r_idx == LAST_IDX);
  assign w_l_next     = {r_l[8:0], ~(r_l[9] ^ r_l[6])};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    Sh_pulse = 1'b0;
    case (r_state)
      S_IDLE:   if (Start) w_next = S_SHIFT;
      S_SHIFT: begin
        Sh_pulse = w_last_phase;
        if (w_last_phase && w_last_bit) w_next = S_DECODE;
      end
      S_DECODE: if (w_lockup || w_match || w_guard) w_next = S_OUTPUT;
      S_OUTPUT: if (w_accept) w_next = w_last_pix ? S_IDLE : S_SHIFT;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_phase   <= '0;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_w       <= '0;
      r_l       <= '0;
      r_c       <= '0;
      r_data    <= '0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_idx     <= '0;
            r_phase   <= '0;
            r_bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          // Sample early in the bit period; the chain is clocked at its end.
          if (r_phase == '0) r_w <= {r_w[8:0], Ser_in};
          if (w_last_phase) begin
            r_phase   <= '0;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (w_last_bit) begin
              r_l <= '0;
              r_c <= '0;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_DECODE: begin
          if (w_lockup || (!w_match && w_guard)) begin
            r_data <= 10'h3FF;
            r_err  <= 1'b1;
          end else if (w_match) begin
            r_data <= r_c;
            r_err  <= 1'b0;
          end else begin
            r_l <= w_l_next;
            r_c <= r_c + 10'd1;
          end
        end
        S_OUTPUT: begin
          if (w_accept) begin
            if (w_last_pix) begin
              r_done <= 1'b1;
            end else begin
              r_idx     <= r_idx + 1'b1;
              r_phase   <= '0;
              r_bit_cnt <= '0;
            end
          end
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign Shift     = (r_state != S_IDLE);
  assign Busy      = (r_state != S_IDLE);
  assign Pix_valid = (r_state == S_OUTPUT);
  assign Pix_addr  = r_idx;
  assign Pix_data  = r_data;
  assign Pix_err   = r_err;
  assign Done      = r_done;
  assign Dbg_state = r_state;

endmodule

// File: tb/tb_pixel_readout_decoder.sv
// Bench for pixel_readout_decoder: a chain model feeds serial words, a table-based
// LFSR model predicts counts, and a monitor pops a scoreboard queue on each accept.
module tb_pixel_readout_decoder;

  localparam int N_PIX = 4;
  localparam int BC    = 4;
  localparam int IDX_W = 2;
  localparam int NBITS = N_PIX * 10;
  localparam int EW    = 11 + 1 + 10 + IDX_W;
  localparam int TO    = 8000;

  // clock / reset
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic             Rst_n;
  logic             Start;
  logic             Ser_in;
  logic             Shift;
  logic             Sh_pulse;
  logic [9:0]       Pix_data;
  logic             Pix_err;
  logic [IDX_W-1:0] Pix_addr;
  logic             Pix_valid;
  logic             Pix_ready;
  logic             Busy;
  logic             Done;
  logic [1:0]       Dbg_state;

  pixel_readout_decoder #(.N_PIX(N_PIX), .BIT_CYCLES(BC), .IDX_W(IDX_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Ser_in(Ser_in),
    .Shift(Shift), .Sh_pulse(Sh_pulse), .Pix_data(Pix_data), .Pix_err(Pix_err),
    .Pix_addr(Pix_addr), .Pix_valid(Pix_valid), .Pix_ready(Pix_ready),
    .Busy(Busy), .Done(Done), .Dbg_state(Dbg_state)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [9:0]    lfsr_tab [0:1022];
  logic [9:0]    frame_words [0:N_PIX-1];
  logic          stream [0:NBITS];
  int            ptr = 0;
  logic [EW-1:0] exp_q[$];
  int            frame_pulses;
  logic          stall_en;
  logic          rand_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: count = position of the word in the LFSR sequence from seed 0
  function automatic logic [EW-1:0] model(input logic [9:0] word, input int addr);
    int cnt;
    cnt = 0;
    if (word == 10'h3FF) return {11'd1, 1'b1, 10'h3FF, IDX_W'(addr)};
    for (int i = 0; i < 1023; i++) if (lfsr_tab[i] == word) cnt = i;
    return {11'(cnt + 1), 1'b0, 10'(cnt), IDX_W'(addr)};
  endfunction

  function automatic logic [9:0] rand_word();
    if ($urandom_range(0, 7) == 0) return 10'h3FF;
    return lfsr_tab[$urandom_range(0, 1022)];
  endfunction

  function automatic logic [31:0] out_vec();
    return 32'({Shift, Sh_pulse, Pix_data, Pix_err, Pix_addr, Pix_valid, Busy, Done});
  endfunction

  // pixel chain: MSB of the nearest pixel first, advances one bit per Sh_pulse
  assign Ser_in = stream[ptr];
  always @(negedge Clk) begin
    if (!Rst_n) ptr = 0;
    else if (Start && !Busy) ptr = 0;
    else if (Sh_pulse && ptr < NBITS) ptr++;
  end

  // consumer: optional 5-cycle stall on pixel 1, otherwise always-ready or random
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    Pix_ready = 1'b1;
    forever begin
      @(posedge Clk); #1;
      if (!Pix_valid) stall_cnt = 0;
      if (stall_en && Pix_valid && Pix_addr == IDX_W'(1) && stall_cnt < 5) begin
        Pix_ready = 1'b0;
        stall_cnt++;
      end else if (rand_ready) Pix_ready = ($urandom_range(0, 3) != 0);
      else Pix_ready = 1'b1;
    end
  end

  // monitor / scoreboard
  logic          prev_valid, prev_ready, done_pending;
  logic [12:0]   held;
  int            since_pulse, pix_pulses;
  logic [EW-1:0] e;

  always @(negedge Clk) begin
    if (!Rst_n) begin
      prev_valid = 0; prev_ready = 0; done_pending = 0;
      since_pulse = 0; pix_pulses = 0; frame_pulses = 0;
    end else begin
      if (Start && !Busy) frame_pulses = 0;
      since_pulse++;
      if (Sh_pulse) begin
        frame_pulses++;
        if (pix_pulses > 0) check("pulse_gap", since_pulse, BC);
        pix_pulses++;
        since_pulse = 0;
      end
      if (Done || done_pending) check("done_pulse", 32'(Done), 32'(done_pending));
      done_pending = 0;
      if (Pix_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_output: addr %0d data 0x%0h with empty queue", Pix_addr, Pix_data);
        end else begin
          e = exp_q[0];
          check("pulses_per_pixel", pix_pulses, 10);
          check("decode_latency", since_pulse, 32'(e[EW-1 -: 11]) + 1);
        end
        pix_pulses = 0;
      end
      if (Pix_valid && prev_valid && !prev_ready)
        check("stall_hold", 32'({Pix_err, Pix_data, Pix_addr}), 32'(held));
      if (Pix_valid && Pix_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pix_data", 32'(Pix_data), 32'(e[IDX_W+9 -: 10]));
        check("pix_err", 32'(Pix_err), 32'(e[IDX_W+10]));
        check("pix_addr", 32'(Pix_addr), 32'(e[IDX_W-1:0]));
        if (Pix_addr == IDX_W'(N_PIX - 1)) done_pending = 1;
      end
      prev_valid = Pix_valid;
      prev_ready = Pix_ready;
      held       = {Pix_err, Pix_data, Pix_addr};
    end
  end

  // driver tasks
  task automatic start_frame();
    for (int p = 0; p < N_PIX; p++) begin
      exp_q.push_back(model(frame_words[p], p));
      for (int k = 0; k < 10; k++) stream[p*10 + k] = frame_words[p][9-k];
    end
    stream[NBITS] = 1'b0;
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
  endtask

  task automatic run_frame(input bit start_while_busy);
    bit got_done;
    got_done = 0;
    start_frame();
    for (int c = 0; c < TO; c++) begin
      @(negedge Clk);
      if (start_while_busy && c == 30) Start = 1'b1;
      if (start_while_busy && c == 31) Start = 1'b0;
      if (Done) begin got_done = 1; break; end
    end
    check("done_seen", 32'(got_done), 1);
    if (got_done) begin
      check("busy_after_done", 32'({Busy, Shift}), 0);
      check("frame_pulses", frame_pulses, NBITS);
      check("queue_drained", exp_q.size(), 0);
    end
    exp_q.delete();
    repeat (3) @(negedge Clk);
    check("idle_after_frame", 32'({Busy, Pix_valid, Sh_pulse}), 0);
  endtask

  initial begin
    logic [9:0] s;
    s = 10'h000;
    for (int i = 0; i < 1023; i++) begin
      lfsr_tab[i] = s;
      s = {s[8:0], ~(s[9] ^ s[6])};
    end
    for (int i = 0; i <= NBITS; i++) stream[i] = 1'b0;
    Rst_n = 1'b0; Start = 1'b0; stall_en = 1'b0; rand_ready = 1'b0;
    repeat (3) @(posedge Clk);
    #1 check("reset_outputs", out_vec(), 0);
    Rst_n = 1'b1;

    frame_words = '{10'h003, 10'h000, 10'h07F, 10'h0FE};
    stall_en = 1'b1;
    run_frame(1);
    stall_en = 1'b0;

    frame_words = '{10'h001, 10'h3FF, 10'h0FE, 10'h07F};
    run_frame(0);

    // reset during the 6th bit of pixel 2, then a clean frame from idx 0
    for (int p = 0; p < N_PIX; p++) frame_words[p] = rand_word();
    start_frame();
    for (int c = 0; c < TO && frame_pulses < 25; c++) @(negedge Clk);
    check("reset_wait", 32'(frame_pulses >= 25), 1);
    @(posedge Clk); #2 Rst_n = 1'b0;
    #1 check("midframe_reset_outputs", out_vec(), 0);
    exp_q.delete();
    @(posedge Clk); #1 Rst_n = 1'b1;
    frame_words = '{10'h000, lfsr_tab[1022], 10'h3FF, lfsr_tab[500]};
    run_frame(0);

    rand_ready = 1'b1;
    repeat (5) begin
      for (int p = 0; p < N_PIX; p++) frame_words[p] = rand_word();
      run_frame(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

endmodule
